// File: rtl/byte_lane_scheduler_if.sv
// rtl/byte_lane_scheduler_if.sv - requester handshake and byte-lane bundle for byte_lane_scheduler
interface byte_lane_scheduler_if;
  localparam int NREQ = 4;

  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [7:0]         out_data8;
  logic               out8;

  // Requester/packer side: offers words, watches the handshake and the lane.
  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_data8,
    input  out8
  );

  // Scheduler side: accepts words and drives the byte lane.
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_data8,
    output out8
  );
endinterface

// File: rtl/byte_lane_scheduler.sv
// rtl/byte_lane_scheduler.sv - round-robin scheduler serializing four 32-bit requesters onto one byte lane
module byte_lane_scheduler (
  input  logic                        clk_4f,
  input  logic                        reset,
  byte_lane_scheduler_if.slave        bus,
  output logic [1:0]                  grant_id,
  output logic                        busy,
  output logic [15:0]                 word_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [1:0]  phase;
  logic [31:0] shift;
  logic [1:0]  last_grant;

  logic        accept_point;
  logic        accept;
  logic        found;
  logic [1:0]  winner;
  logic [1:0]  cand;
  logic [31:0] win_word;
  logic        word_done;

  // The lane is free for a new word when idle or while the last byte of the current word is out.
  assign accept_point = (state == IDLE) || ((state == SEND) && (phase == 2'd3));
  assign word_done    = (state == SEND) && (phase == 2'd3);
  assign accept       = !reset && accept_point && found;

  // Round-robin search starting one past the most recent grant.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign win_word      = bus.req_data[{winner, 5'd0} +: 32];
  assign bus.req_ready = accept ? (4'b0001 << winner) : 4'b0000;

  // Capture, serialize MSB-first and count completed words; an accept at phase 3 chains words with no bubble.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= 2'd0;
      shift         <= 32'd0;
      last_grant    <= 2'd3;
      grant_id      <= 2'd0;
      bus.out_data8 <= 8'd0;
      bus.out8      <= 1'b0;
      busy          <= 1'b0;
      word_count    <= 16'd0;
    end else begin
      if (word_done) begin
        word_count <= word_count + 16'd1;
      end
      if (accept) begin
        state         <= SEND;
        phase         <= 2'd0;
        shift         <= {win_word[23:0], 8'h00};
        bus.out_data8 <= win_word[31:24];
        bus.out8      <= 1'b1;
        busy          <= 1'b1;
        last_grant    <= winner;
        grant_id      <= winner;
      end else if (state == SEND) begin
        if (phase == 2'd3) begin
          state         <= IDLE;
          phase         <= 2'd0;
          shift         <= 32'd0;
          bus.out_data8 <= 8'd0;
          bus.out8      <= 1'b0;
          busy          <= 1'b0;
        end else begin
          bus.out_data8 <= shift[31:24];
          shift         <= {shift[23:0], 8'h00};
          phase         <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_lane_scheduler.sv
// tb/tb_byte_lane_scheduler.sv - scoreboard bench for byte_lane_scheduler
module tb_byte_lane_scheduler;

  logic        clk_4f;
  logic        reset;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] word_count;

  byte_lane_scheduler_if bus ();

  byte_lane_scheduler dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .word_count (word_count)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    bit         last;
  } lane_byte_t;

  lane_byte_t  sb[$];
  lane_byte_t  item;
  int          checks = 0;
  int          errors = 0;
  int          exp_last = 3;
  logic [15:0] exp_count = 16'd0;
  logic [1:0]  exp_gid = 2'd0;
  logic [3:0]  exp_ready;
  logic [31:0] mon_word;
  bit          have;

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pops the expected byte each cycle, pushes a whole word whenever the model says the lane is free.
  always @(negedge clk_4f) begin
    if (reset) begin
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL ready_in_reset: got %b expected 0000", bus.req_ready);
      end
      sb.delete();
      exp_last  = 3;
      exp_count = 16'd0;
      exp_gid   = 2'd0;
    end else begin
      have = 1'b0;
      if (sb.size() > 0) begin
        item = sb.pop_front();
        have = 1'b1;
      end
      checks++;
      if (have) begin
        if (bus.out8 !== 1'b1 || bus.out_data8 !== item.data || grant_id !== item.id || busy !== 1'b1) begin
          errors++;
          $display("FAIL lane_byte: got out8=%b data=%h gid=%0d busy=%b expected out8=1 data=%h gid=%0d busy=1",
                   bus.out8, bus.out_data8, grant_id, busy, item.data, item.id);
        end
      end else begin
        if (bus.out8 !== 1'b0 || bus.out_data8 !== 8'h00 || busy !== 1'b0 || grant_id !== exp_gid) begin
          errors++;
          $display("FAIL lane_idle: got out8=%b data=%h gid=%0d busy=%b expected out8=0 data=00 gid=%0d busy=0",
                   bus.out8, bus.out_data8, grant_id, busy, exp_gid);
        end
      end
      checks++;
      if (word_count !== exp_count) begin
        errors++;
        $display("FAIL word_count_track: got %h expected %h", word_count, exp_count);
      end
      if (have && item.last) exp_count = exp_count + 16'd1;
      exp_ready = 4'b0000;
      if (sb.size() == 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (exp_last + k) % 4;
          if (bus.req_valid[c] === 1'b1) begin
            exp_ready[c] = 1'b1;
            mon_word = bus.req_data[32*c +: 32];
            for (int b = 0; b < 4; b++) begin
              item.data = mon_word[31-8*b -: 8];
              item.id   = 2'(c);
              item.last = (b == 3);
              sb.push_back(item);
            end
            exp_last = c;
            exp_gid  = 2'(c);
            break;
          end
        end
      end
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
      end
    end
  end

  function automatic int idx_of(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic wait_accept(input int budget, output logic [3:0] rdy, output bit ok);
    ok  = 1'b0;
    rdy = 4'b0000;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_4f);
      if (bus.req_ready !== 4'b0000) begin
        rdy = bus.req_ready;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_4f);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_4f); #1;
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    repeat (3) @(posedge clk_4f);
    #1;
    v = bus.req_ready;
    checks++;
    if (v !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", v);
    end
    checks++;
    if (bus.out8 !== 1'b0 || bus.out_data8 !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got out8=%b data=%h busy=%b gid=%0d count=%h expected 0 00 0 0 0000",
               bus.out8, bus.out_data8, busy, grant_id, word_count);
    end
    bus.req_valid = 4'b0000;
    reset = 1'b0;
    repeat (2) @(negedge clk_4f);
  endtask

  task automatic test_single_word();
    logic [3:0] rdy;
    bit ok;
    bus.req_data[31:0] = 32'hA1B2C3D4;
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0001;
    wait_accept(20, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b ok=%0d expected 0001", rdy, ok);
    end
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0000;
    wait_drain(20, ok);
    checks++;
    if (!ok || bus.out8 !== 1'b0 || word_count !== 16'd1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_end: got out8=%b count=%h gid=%0d drained=%0d expected 0 0001 0 1",
               bus.out8, word_count, grant_id, ok);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy;
    bit ok;
    int grants[$];
    int gaps;
    apply_reset();
    bus.req_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    bus.req_valid = 4'b1111;
    gaps = 0;
    wait_accept(20, rdy, ok);
    grants.push_back(idx_of(rdy));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_4f);
      if (bus.out8 !== 1'b1) gaps++;
      if (bus.req_ready !== 4'b0000) grants.push_back(idx_of(bus.req_ready));
      if (c == 15) begin
        @(posedge clk_4f); #1;
        bus.req_valid = 4'b0000;
      end
    end
    wait_drain(20, ok);
    checks++;
    if (grants.size() != 5 || grants[0] != 0 || grants[1] != 1 || grants[2] != 2 || grants[3] != 3 || grants[4] != 0) begin
      errors++;
      $display("FAIL rr_order: got %p expected 0 1 2 3 0", grants);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL rr_contiguous: got %0d gaps expected 0", gaps);
    end
    checks++;
    if (!ok || word_count !== 16'd5) begin
      errors++;
      $display("FAIL rr_count: got %h drained=%0d expected 0005", word_count, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy;
    bit ok;
    int pulse_at[$];
    int gaps;
    bus.req_data[95:64] = 32'h5A6B7C8D;
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0100;
    gaps = 0;
    wait_accept(20, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_first: got %b expected 0100", rdy);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_4f);
      if (bus.out8 !== 1'b1) gaps++;
      if (bus.req_ready === 4'b0100) pulse_at.push_back(c);
      if (c == 7) begin
        @(posedge clk_4f); #1;
        bus.req_valid = 4'b0000;
      end
    end
    wait_drain(20, ok);
    checks++;
    if (pulse_at.size() != 2 || pulse_at[0] != 3 || pulse_at[1] != 7) begin
      errors++;
      $display("FAIL b2b_pulses: got %p expected 3 7", pulse_at);
    end
    checks++;
    if (gaps != 0 || !ok || grant_id !== 2'd2 || word_count !== 16'd8) begin
      errors++;
      $display("FAIL b2b_end: got gaps=%0d gid=%0d count=%h expected 0 2 0008", gaps, grant_id, word_count);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] rdy;
    bit ok;
    int grants[$];
    bus.req_data = {32'hF3F3F3F3, 32'h0, 32'hF1F1F1F1, 32'hF0F0F0F0};
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0010;
    wait_accept(20, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0010) begin
      errors++;
      $display("FAIL fair_setup: got %b expected 0010", rdy);
    end
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_accept(10, rdy, ok);
      grants.push_back(ok ? idx_of(rdy) : -1);
    end
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0000;
    wait_drain(20, ok);
    checks++;
    if (grants.size() != 3 || grants[0] != 3 || grants[1] != 0 || grants[2] != 1) begin
      errors++;
      $display("FAIL fair_order: got %p expected 3 0 1", grants);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] rdy;
    bit ok;
    bus.req_data[31:0] = 32'hDEADBEEF;
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0001;
    wait_accept(20, rdy, ok);
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0000;
    @(posedge clk_4f); #1;
    checks++;
    if (bus.out8 !== 1'b1 || bus.out_data8 !== 8'hAD) begin
      errors++;
      $display("FAIL mid_phase1: got out8=%b data=%h expected 1 ad", bus.out8, bus.out_data8);
    end
    reset = 1'b1;
    @(posedge clk_4f); #1;
    reset = 1'b0;
    checks++;
    if (bus.out8 !== 1'b0 || bus.out_data8 !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_values: got out8=%b data=%h busy=%b gid=%0d count=%h expected 0 00 0 0 0000",
               bus.out8, bus.out_data8, busy, grant_id, word_count);
    end
    bus.req_data[63:32] = 32'h01020304;
    bus.req_valid = 4'b0010;
    wait_accept(20, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0010) begin
      errors++;
      $display("FAIL mid_after_grant: got %b expected 0010", rdy);
    end
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0000;
    wait_drain(20, ok);
    checks++;
    if (!ok || grant_id !== 2'd1 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_after_end: got gid=%0d count=%h expected 1 0001", grant_id, word_count);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rdy;
    bit ok;
    @(posedge clk_4f); #1;
    force dut.word_count = 16'hFFFF;
    exp_count = 16'hFFFF;
    #1;
    release dut.word_count;
    #1;
    checks++;
    if (word_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", word_count);
    end
    bus.req_data[95:64] = 32'hCAFEF00D;
    bus.req_valid = 4'b0100;
    wait_accept(20, rdy, ok);
    @(posedge clk_4f); #1;
    bus.req_valid = 4'b0000;
    wait_drain(20, ok);
    checks++;
    if (!ok || word_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count: got %h expected 0000", word_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_data  = '0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_back_to_back();
    test_fairness();
    test_reset_mid_word();
    test_wrap();
    repeat (4) @(posedge clk_4f);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_lane_scheduler.md
# byte_lane_scheduler

Round-robin scheduler that shares the single 8-bit byte lane feeding the 8-to-32 packer among four 32-bit word requesters. It grants one requester at a time and serializes the granted word MSB-first as four consecutive valid bytes on clk_4f. It starts the next word back-to-back with no bubble, so the packer sees contiguous 4-byte groups aligned to word boundaries. It sits on the clk_4f side, directly upstream of the 8-to-32 conversion path.

## Interface
- NREQ, 4: number of requesters; fixed at 4, other values are not supported.
- clk_4f  input  1  byte-rate clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  4  bit i high means requester i holds a word on its slice of req_data.
- req_data  input  128  word of requester i is bits [32*i+31 : 32*i]. It must stay stable while req_valid[i] is high and req_ready[i] is low.
- req_ready  output  4  combinational, one-hot or zero. Bit i high means the word of requester i is captured at this edge.
- out_data8  output  8  registered byte to the packer.
- out8  output  1  registered byte-valid to the packer.
- grant_id  output  2  registered index of the requester whose word is currently on the lane.
- busy  output  1  registered; high while a word is being serialized.
- word_count  output  16  registered count of words fully sent; wraps from 0xFFFF to 0.

## Operation
- State machine: IDLE and SEND. phase[1:0] counts bytes within SEND (0..3). A 32-bit shift register holds the granted word. last_grant[1:0] is the round-robin pointer.
- Arbitration: the search starts at last_grant+1 mod 4 and takes the first i with req_valid[i]=1.
- Accept points:
  - state==IDLE with any req_valid set.
  - state==SEND with phase==3 and any req_valid set (back-to-back).
- req_ready is nonzero only at an accept point, and then only for the winning index. At that edge: the word is captured, last_grant and grant_id take the winner, phase goes to 0, and state goes to SEND.
- SEND behaviour:
  - Each cycle, out_data8 is the shift register's [31:24], out8=1, the shift register shifts left by 8, and phase increments.
  - Bytes leave in order [31:24], [23:16], [15:8], [7:0].
- Word completion at phase==3: word_count increments by 1, modulo 2^16. If there is no accept, state goes to IDLE. If there is an accept, state stays in SEND with the new word.
- IDLE: out8=0, out_data8=0, busy=0. grant_id holds its last value.
- busy is 1 in every cycle where out8 is 1.
- A requester whose valid drops before it is granted is simply skipped. No word is partially sent; once captured, a word always completes all 4 bytes.

## Timing
- Reset values: state=IDLE, phase=0, last_grant=3 (requester 0 has first priority), grant_id=0, out_data8=0, out8=0, busy=0, word_count=0. req_ready=0 while reset is high.
- Latency: accept at edge N gives the MSB on out_data8 with out8=1 in the cycle following edge N. The last byte is valid in the cycle after edge N+3.
- Throughput: with continuous requests, out8 stays 1 indefinitely and each word takes exactly 4 clk_4f cycles (one clk_f period).
- Simultaneous events:
  - The completion of word k and the accept of word k+1 happen at the same edge. word_count increments and grant_id changes at that edge.
  - Ties go strictly round-robin: no requester waits more than 3 words while its valid is held.
- Reset mid-word: the in-flight word is discarded, out8=0 from the cycle after the reset edge, and the word is not counted. The requester's handshake already completed, so it is not re-requested.

## Test plan
- Single word: req_valid=0001 with word 0xA1B2C3D4. Required: req_ready=0001 for one cycle, then out_data8 = A1, B2, C3, D4 with out8=1 for 4 cycles, then out8=0, word_count=1, grant_id=0.
- All four requesting continuously, with words 0x00000000, 0x11111111, 0x22222222, 0x33333333 held: grants go 0,1,2,3,0, out8 never drops across 20 cycles, and word_count=5.
- Back-to-back from the same requester: req_valid=0100 held high for 3 words. Required: 12 contiguous valid bytes, req_ready[2] pulsing every 4th cycle, grant_id=2.
- Fairness: after granting 1, req_valid=1011 at the phase-3 edge. Required next grant is 3, then 0, then 1.
- Reset at phase 1 of word 0xDEADBEEF: out8=0 in the cycle after reset, all outputs at reset values, word_count=0. After reset, a req_valid=0010 word is granted first as requester 1.
- Wrap: preload 0xFFFF completed words (65535 sends), then send one more word. Required: word_count=0x0000.
